// File: rtl/mem_access_ctrl.sv
// Initiator side of the MFA/MFC four-phase memory handshake toward ram_256b.
// Define MAC_TIMEOUT_EN to enable the per-phase watchdog in ASSERT and RELEASE.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned SETUP_CYCLES   = 3,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [5:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              misaligned,
  output logic              timeout,
  output logic              MFA,
  output logic [5:0]        opcode,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              MFC
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned SETUP_W = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  localparam logic [OP_W-1:0] OP_LDUB = 6'h01;
  localparam logic [OP_W-1:0] OP_LDSB = 6'h09;
  localparam logic [OP_W-1:0] OP_LDUH = 6'h02;
  localparam logic [OP_W-1:0] OP_LDSH = 6'h0A;
  localparam logic [OP_W-1:0] OP_LD   = 6'h08;
  localparam logic [OP_W-1:0] OP_STB  = 6'h05;
  localparam logic [OP_W-1:0] OP_STH  = 6'h06;
  localparam logic [OP_W-1:0] OP_ST   = 6'h04;

  // Parameter sanity, evaluated at elaboration
  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("SETUP_CYCLES must be at least 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FAULT,
    S_SETUP,
    S_ASSERT,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t              r_state;
  logic [SETUP_W-1:0]  r_setup_cnt;
  logic [SYNC_STAGES-1:0] r_mfc_sync;
  logic                r_busy;
  logic                r_done;
  logic                r_misaligned;
  logic                r_mfa;
  logic [OP_W-1:0]     r_opcode;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data_in;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_mfc_s;
  logic                w_req_fault;
  logic                w_is_load;

  // MFC is asynchronous; only the last synchronizer stage is used by the FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mfc_sync <= '0;
    end else begin
      r_mfc_sync <= {r_mfc_sync[SYNC_STAGES-2:0], MFC};
    end
  end

  assign w_mfc_s = r_mfc_sync[SYNC_STAGES-1];

  // Request check: unknown opcode or natural-alignment violation
  always_comb begin
    w_req_fault = 1'b0;
    case (req_op)
      OP_LDUB, OP_LDSB, OP_STB: w_req_fault = 1'b0;
      OP_LDUH, OP_LDSH, OP_STH: w_req_fault = req_addr[0];
      OP_LD, OP_ST:             w_req_fault = |req_addr[1:0];
      default:                  w_req_fault = 1'b1;
    endcase
  end

  always_comb begin
    w_is_load = 1'b0;
    case (r_opcode)
      OP_LDUB, OP_LDSB, OP_LDUH, OP_LDSH, OP_LD: w_is_load = 1'b1;
      default:                                   w_is_load = 1'b0;
    endcase
  end

`ifdef MAC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_wdog;
  logic            r_timeout;
  logic            w_wdog_hit;

  assign w_wdog_hit = (r_wdog == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout    = r_timeout;
`else
  assign timeout    = 1'b0;
`endif

  // Handshake sequencer; every output changes only on a clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_setup_cnt  <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_misaligned <= 1'b0;
      r_mfa        <= 1'b0;
      r_opcode     <= '0;
      r_addr       <= '0;
      r_data_in    <= '0;
      r_rdata      <= '0;
`ifdef MAC_TIMEOUT_EN
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_opcode    <= req_op;
            r_addr      <= req_addr;
            r_data_in   <= req_wdata;
            r_busy      <= 1'b1;
            r_setup_cnt <= '0;
            r_state     <= w_req_fault ? S_FAULT : S_SETUP;
          end
        end

        S_FAULT: begin
          r_done       <= 1'b1;
          r_misaligned <= 1'b1;
          r_state      <= S_DONE;
        end

        S_SETUP: begin
          if (r_setup_cnt == SETUP_W'(SETUP_CYCLES - 1)) begin
            r_mfa   <= 1'b1;
            r_state <= S_ASSERT;
`ifdef MAC_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end else begin
            r_setup_cnt <= r_setup_cnt + 1'b1;
          end
        end

        S_ASSERT: begin
          if (w_mfc_s) begin
            r_mfa   <= 1'b0;
            r_state <= S_RELEASE;
            if (w_is_load) begin
              r_rdata <= mem_data;
            end
`ifdef MAC_TIMEOUT_EN
            r_wdog  <= '0;
          end else if (w_wdog_hit) begin
            r_mfa     <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
`endif
          end
        end

        // Wait for the memory to drop MFC to close the four-phase cycle
        S_RELEASE: begin
          if (!w_mfc_s) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
`ifdef MAC_TIMEOUT_EN
          end else if (w_wdog_hit) begin
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
`endif
          end
        end

        S_DONE: begin
          r_busy       <= 1'b0;
          r_misaligned <= 1'b0;
`ifdef MAC_TIMEOUT_EN
          r_timeout    <= 1'b0;
`endif
          r_state      <= S_IDLE;
        end

        default: begin
          r_mfa   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign rdata      = r_rdata;
  assign misaligned = r_misaligned;
  assign MFA        = r_mfa;
  assign opcode     = r_opcode;
  assign addr       = r_addr;
  assign data_in    = r_data_in;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a random-delay ram_256b responder plus a
// byte-array reference memory that predicts every completion.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned DATA_W         = 32;
  localparam int unsigned SETUP_CYCLES   = 3;
  localparam int unsigned SYNC_STAGES    = 2;
  localparam int unsigned TIMEOUT_CYCLES = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req;
  logic [5:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy, done, misaligned, timeout, MFA;
  logic [DATA_W-1:0] rdata, data_in, mem_data;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] addr;
  logic              MFC;

  mem_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETUP_CYCLES(SETUP_CYCLES),
    .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata),
    .misaligned(misaligned), .timeout(timeout), .MFA(MFA), .opcode(opcode),
    .addr(addr), .data_in(data_in), .mem_data(mem_data), .MFC(MFC)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]        op;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rdata;
    bit                fault;
    bit                tmo;
    int unsigned       rises;
    longint unsigned   issue;
  } exp_t;

  exp_t              sb_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  longint unsigned   cyc = 0;
  int unsigned       mfa_rises = 0;
  logic              mfa_d = 1'b0;
  bit                ram_stall = 1'b0;
  logic [7:0]        model_mem[256];
  logic [7:0]        ram_mem[256];
  logic [DATA_W-1:0] model_rdata = '0;
  logic [5:0]        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wd;
  longint unsigned   cur_issue;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Access size in bytes; 0 marks an opcode outside the SPARC load/store set
  function automatic int unsigned op_size(input logic [5:0] op);
    case (op)
      6'h01, 6'h09, 6'h05: return 1;
      6'h02, 6'h0A, 6'h06: return 2;
      6'h08, 6'h04:        return 4;
      default:             return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [5:0] op);
    return op inside {6'h01, 6'h09, 6'h02, 6'h0A, 6'h08};
  endfunction

  function automatic bit op_signed(input logic [5:0] op);
    return op inside {6'h09, 6'h0A};
  endfunction

  // Big-endian read of sz bytes with optional sign extension
  function automatic logic [31:0] be_extend(input logic [63:0] raw, input int unsigned sz, input bit sgn);
    logic [63:0] v;
    v = raw;
    if (sgn && sz < 4 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
    return v[31:0];
  endfunction

  // ram_256b stand-in: performs the access some cycles after MFA, then follows MFA down
  initial begin
    int k;
    logic [63:0] v;
    int unsigned sz;
    MFC = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (MFA && !ram_stall) begin
        check("setup_hold_cycles", cyc - cur_issue, 64'(1 + SETUP_CYCLES));
        check("ram_opcode", 64'(opcode), 64'(cur_op));
        check("ram_addr", 64'(addr), 64'(cur_addr));
        check("ram_data_in", 64'(data_in), 64'(cur_wd));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sz = op_size(opcode);
        if (op_load(opcode)) begin
          v = '0;
          for (int i = 0; i < int'(sz); i++) v = (v << 8) | 64'(ram_mem[(int'(addr) + i) % 256]);
          mem_data = be_extend(v, sz, op_signed(opcode));
        end else begin
          for (int i = 0; i < int'(sz); i++)
            ram_mem[(int'(addr) + i) % 256] = 8'(data_in >> (8 * (int'(sz) - 1 - i)));
          mem_data = DATA_W'($urandom);
        end
        MFC = 1'b1;
        k = 0;
        while (MFA && k < 200) begin
          @(negedge clk);
          k++;
        end
        if (k >= 200) check("mfa_release_bound", 64'(MFA), 64'(0));
        repeat ($urandom_range(0, 3)) @(negedge clk);
        MFC = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (MFA && !mfa_d) mfa_rises++;
    mfa_d = MFA;
  end

  // Monitor: every done pulse consumes exactly one predicted completion
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(done), 64'(0));
      end else begin
        e = sb_q.pop_front();
        check("misaligned", 64'(misaligned), 64'(e.fault));
        check("timeout", 64'(timeout), 64'(e.tmo));
        check("rdata", 64'(rdata), 64'(e.rdata));
        check("busy_at_done", 64'(busy), 64'(1));
        check("mfa_rise_count", 64'(mfa_rises), 64'(e.rises));
        check("opcode_held", 64'(opcode), 64'(e.op));
        check("addr_held", 64'(addr), 64'(e.a));
        check("data_in_held", 64'(data_in), 64'(e.wd));
        if (e.fault) check("fault_latency", cyc - e.issue, 64'(2));
        mfa_rises = 0;
      end
    end
  end

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy && k < 1000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 1000) check(name, 64'(busy), 64'(0));
  endtask

  // Issue one request from IDLE; expected result is predicted and queued first
  task automatic issue(input logic [5:0] op, input logic [7:0] a, input logic [31:0] wd,
                       input bit pulse_busy, input bit stall);
    exp_t e;
    int unsigned sz;
    logic [63:0] v;
    @(negedge clk);
    sz = op_size(op);
    e.fault = (sz == 0) || (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    e.tmo   = stall && !e.fault;
    e.rises = e.fault ? 0 : 1;
    if (!e.fault && !stall) begin
      if (op_load(op)) begin
        v = '0;
        for (int i = 0; i < int'(sz); i++) v = (v << 8) | 64'(model_mem[(int'(a) + i) % 256]);
        model_rdata = be_extend(v, sz, op_signed(op));
      end else begin
        for (int i = 0; i < int'(sz); i++)
          model_mem[(int'(a) + i) % 256] = 8'(wd >> (8 * (int'(sz) - 1 - i)));
      end
    end
    e.rdata = model_rdata;
    e.op = op;
    e.a = a;
    e.wd = wd;
    e.issue = cyc;
    sb_q.push_back(e);
    cur_op = op;
    cur_addr = a;
    cur_wd = wd;
    cur_issue = cyc;
    ram_stall = stall;
    req = 1'b1;
    req_op = op;
    req_addr = a;
    req_wdata = wd;
    @(negedge clk);
    req = 1'b0;
    req_op = 6'($urandom);
    req_addr = 8'($urandom);
    req_wdata = $urandom;
    if (pulse_busy) begin
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
    wait_idle("done_wait_bound");
    ram_stall = 1'b0;
    check("one_done_per_req", 64'(sb_q.size()), 64'(0));
    check("done_low_after", 64'(done), 64'(0));
  endtask

  // Reset while MFA is high must abort the transfer on the following edge
  task automatic reset_mid();
    int k;
    @(negedge clk);
    cur_op = 6'h08;
    cur_addr = 8'h04;
    cur_wd = 32'h1234_5678;
    cur_issue = cyc;
    req = 1'b1;
    req_op = 6'h08;
    req_addr = 8'h04;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    req = 1'b0;
    k = 0;
    while (!MFA && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("mfa_seen_before_reset", 64'(MFA), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_mfa", 64'(MFA), 64'(0));
    check("reset_mid_busy", 64'(busy), 64'(0));
    check("reset_mid_rdata", 64'(rdata), 64'(0));
    reset = 1'b0;
    model_rdata = '0;
    repeat (12) @(negedge clk);
    mfa_rises = 0;
  endtask

  initial begin
    logic [5:0] ops[8];
    logic [5:0] op;
    logic [7:0] a;
    ops = '{6'h01, 6'h09, 6'h02, 6'h0A, 6'h08, 6'h05, 6'h06, 6'h04};
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 8'(i) ^ 8'h5A;
      ram_mem[i]   = 8'(i) ^ 8'h5A;
    end
    reset = 1'b1;
    req = 1'b0;
    req_op = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mfa", 64'(MFA), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_misaligned", 64'(misaligned), 64'(0));
    check("rst_timeout", 64'(timeout), 64'(0));
    check("rst_opcode", 64'(opcode), 64'(0));
    check("rst_addr", 64'(addr), 64'(0));
    check("rst_data_in", 64'(data_in), 64'(0));
    check("rst_rdata", 64'(rdata), 64'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    issue(6'h05, 8'h00, 32'h0000_0001, 1'b0, 1'b0);
    issue(6'h01, 8'h00, 32'h0, 1'b0, 1'b0);
    issue(6'h06, 8'h02, 32'h0000_4567, 1'b0, 1'b0);
    issue(6'h0A, 8'h02, 32'h0, 1'b0, 1'b0);
    issue(6'h02, 8'h03, 32'h0, 1'b0, 1'b0);
    issue(6'h04, 8'h04, 32'h89ab_cdef, 1'b0, 1'b0);
    issue(6'h08, 8'h04, 32'h0, 1'b0, 1'b0);
    issue(6'h09, 8'h04, 32'h0, 1'b0, 1'b0);
    issue(6'h3F, 8'h00, 32'h0, 1'b0, 1'b0);
    issue(6'h3F, 8'h10, 32'h0, 1'b1, 1'b0);
    issue(6'h08, 8'h04, 32'h0, 1'b1, 1'b0);
    issue(6'h08, 8'h06, 32'h0, 1'b0, 1'b0);
    reset_mid();
    issue(6'h08, 8'h04, 32'h0, 1'b0, 1'b0);

`ifdef MAC_TIMEOUT_EN
    issue(6'h08, 8'h08, 32'h0, 1'b0, 1'b1);
`endif

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 7)] : 6'($urandom);
      a = 8'($urandom);
      if ($urandom_range(0, 9) < 6) a = a & 8'hFC;
      issue(op, a, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
